fir_decim_fifo: RTL and testbench



---
 rtl/fir_decim_fifo_if.sv | 23 ++
 rtl/fir_decim_fifo.sv | 117 +++++++++++
 tb/tb_fir_decim_fifo.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_decim_fifo_if.sv
// AXI-Stream style handshake bundle (valid / ready / data) used on both
// sides of the decimating FIFO.
interface fir_decim_fifo_if #(
  parameter int DATA_W = 16
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;

  // Producer side: drives valid and data, observes ready.
  modport master (
    output tvalid,
    output tdata,
    input  tready
  );

  // Consumer side: observes valid and data, drives ready.
  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/fir_decim_fifo.sv
// Boxcar-average decimator followed by a first-word-fall-through FIFO.
// Groups of DECIM signed samples are summed and divided by DECIM using an
// arithmetic shift, which floors the result. Each average is written into a
// small circular buffer. The buffer is read out through an AXI-Stream
// master that supports full backpressure. Input ready depends only on
// registered state, so it never has a combinational path from the
// downstream ready.
module fir_decim_fifo #(
  parameter int DATA_W = 16,
  parameter int DECIM  = 4,
  parameter int DEPTH  = 8
) (
  input  logic                   aclk,
  input  logic                   areset,
  fir_decim_fifo_if.slave        s_axis_data,
  fir_decim_fifo_if.master       m_axis_data,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int LOG2_DECIM = $clog2(DECIM);
  localparam int PH_W       = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam int ACC_W      = DATA_W + LOG2_DECIM;
  localparam int PTR_W      = $clog2(DEPTH);
  localparam int LVL_W      = PTR_W + 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DECIM - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  // Decimator state
  logic [PH_W-1:0]          phase;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] x;
  logic signed [ACC_W-1:0]  x_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0]        push_data;

  // FIFO state
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  // Handshake events
  logic accept;
  logic push;
  logic pop;

  assign x     = s_axis_data.tdata;
  assign x_ext = ACC_W'(x);

  // While the FIFO is full, a group may still collect samples. Only the
  // closing sample, which would need a free slot, is held off.
  assign s_axis_data.tready = (phase != PH_LAST) | (fifo_level != LVL_FULL);

  assign accept = s_axis_data.tvalid & s_axis_data.tready;
  assign push   = accept & (phase == PH_LAST);
  assign pop    = m_axis_data.tvalid & m_axis_data.tready;

  // Running group sum including the current sample, and its floored average.
  always_comb begin
    // NOTE: give every always_comb target a default before any condition,
    // so that no path can leave it unassigned and infer a latch.
    sum = x_ext;
    if (phase != '0) begin
      sum = acc + x_ext;
    end
    shifted   = sum >>> LOG2_DECIM;
    push_data = shifted[DATA_W-1:0];
  end

  // Group phase and accumulator advance only on an accepted sample.
  always_ff @(posedge aclk or posedge areset) begin
    // NOTE: registers use non-blocking assignments. Every flop then samples
    // the values from before the edge, regardless of block order.
    if (areset) begin
      phase <= '0;
      acc   <= '0;
    end else if (accept) begin
      acc   <= sum;
      phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
    end
  end

  // FIFO storage is written on push.
  always_ff @(posedge aclk) begin
    // NOTE: the storage array has no reset on purpose. The pointers and the
    // level define which entries are valid, and a reset here would prevent
    // mapping the array to RAM.
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers and occupancy. A simultaneous push and pop leaves the
  // level unchanged.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // The head word falls through to the output. Data reads as zero while
  // the FIFO is empty.
  assign m_axis_data.tvalid = (fifo_level != '0);
  assign m_axis_data.tdata  = m_axis_data.tvalid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed testbench for fir_decim_fifo with the default parameters
// (DATA_W=16, DECIM=4, DEPTH=8). Inputs change 1 ns after each rising edge,
// and outputs are sampled at that same point.
module tb_fir_decim_fifo;

  logic       aclk;
  logic       areset;
  logic [3:0] fifo_level;
  int         n_checks;
  int         n_fail;

  fir_decim_fifo_if #(.DATA_W(16)) s_axis_data ();
  fir_decim_fifo_if #(.DATA_W(16)) m_axis_data ();

  fir_decim_fifo #(
    .DATA_W (16),
    .DECIM  (4),
    .DEPTH  (8)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .s_axis_data (s_axis_data),
    .m_axis_data (m_axis_data),
    .fifo_level  (fifo_level)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Presents one sample for a single cycle. Callers use it only while
  // s_axis_data.tready is known to be high.
  task automatic drive(input logic [15:0] v);
    s_axis_data.tvalid = 1'b1;
    s_axis_data.tdata  = v;
    step();
    s_axis_data.tvalid = 1'b0;
    s_axis_data.tdata  = '0;
  endtask

  task automatic test_reset();
    areset             = 1'b1;
    s_axis_data.tvalid = 1'b0;
    s_axis_data.tdata  = '0;
    m_axis_data.tready = 1'b0;
    repeat (2) step();
    n_checks++;
    if (m_axis_data.tvalid !== 1'b0 || m_axis_data.tdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL por_out: tvalid=%0b tdata=%0d, expected 0/0", m_axis_data.tvalid, m_axis_data.tdata);
    end
    n_checks++;
    if (fifo_level !== 4'd0 || s_axis_data.tready !== 1'b1) begin
      n_fail++;
      $display("FAIL por_state: level=%0d s_tready=%0b, expected 0/1", fifo_level, s_axis_data.tready);
    end
    areset = 1'b0;
    // Three full groups with the output stalled, then two samples of a fourth group.
    for (int i = 1; i <= 12; i++) drive(16'(i));
    drive(16'd5);
    drive(16'd6);
    n_checks++;
    if (fifo_level !== 4'd3) begin
      n_fail++;
      $display("FAIL pre_reset_level: got %0d expected 3", fifo_level);
    end
    areset = 1'b1;
    #1;
    n_checks++;
    if (m_axis_data.tvalid !== 1'b0 || fifo_level !== 4'd0 || s_axis_data.tready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: tvalid=%0b level=%0d s_tready=%0b, expected 0/0/1",
               m_axis_data.tvalid, fifo_level, s_axis_data.tready);
    end
    step();
    areset             = 1'b0;
    m_axis_data.tready = 1'b1;
    for (int i = 0; i < 4; i++) drive(16'd10);
    n_checks++;
    if (m_axis_data.tvalid !== 1'b1 || m_axis_data.tdata !== 16'd10 || fifo_level !== 4'd1) begin
      n_fail++;
      $display("FAIL post_reset_group: tvalid=%0b tdata=%0d level=%0d, expected 1/10/1",
               m_axis_data.tvalid, $signed(m_axis_data.tdata), fifo_level);
    end
    step();
    n_checks++;
    if (m_axis_data.tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_drain: tvalid=%0b expected 0", m_axis_data.tvalid);
    end
  endtask

  task automatic test_average();
    m_axis_data.tready = 1'b1;
    drive(16'd100);
    drive(16'd200);
    drive(16'd300);
    n_checks++;
    if (m_axis_data.tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL avg_early: tvalid=%0b expected 0 before closing sample", m_axis_data.tvalid);
    end
    drive(16'd400);
    n_checks++;
    if (m_axis_data.tvalid !== 1'b1 || m_axis_data.tdata !== 16'd250) begin
      n_fail++;
      $display("FAIL avg_word: tvalid=%0b tdata=%0d, expected 1/250",
               m_axis_data.tvalid, $signed(m_axis_data.tdata));
    end
    step();
    n_checks++;
    if (m_axis_data.tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL avg_one_cycle: tvalid=%0b expected 0", m_axis_data.tvalid);
    end
  endtask

  task automatic test_rounding();
    m_axis_data.tready = 1'b1;
    drive(16'hFFFF); drive(16'hFFFE); drive(16'hFFFD); drive(16'hFFFD);
    n_checks++;
    if (m_axis_data.tvalid !== 1'b1 || m_axis_data.tdata !== 16'hFFFD) begin
      n_fail++;
      $display("FAIL round_neg: tvalid=%0b tdata=%0d, expected 1/-3",
               m_axis_data.tvalid, $signed(m_axis_data.tdata));
    end
    step();
    drive(16'd1); drive(16'd1); drive(16'd1); drive(16'd0);
    n_checks++;
    if (m_axis_data.tvalid !== 1'b1 || m_axis_data.tdata !== 16'd0) begin
      n_fail++;
      $display("FAIL round_pos: tvalid=%0b tdata=%0d, expected 1/0",
               m_axis_data.tvalid, $signed(m_axis_data.tdata));
    end
    step();
  endtask

  task automatic test_extremes();
    m_axis_data.tready = 1'b1;
    for (int i = 0; i < 4; i++) drive(16'h7FFF);
    n_checks++;
    if (m_axis_data.tvalid !== 1'b1 || m_axis_data.tdata !== 16'h7FFF) begin
      n_fail++;
      $display("FAIL ext_max: tvalid=%0b tdata=%0d, expected 1/32767",
               m_axis_data.tvalid, $signed(m_axis_data.tdata));
    end
    step();
    for (int i = 0; i < 4; i++) drive(16'h8000);
    n_checks++;
    if (m_axis_data.tvalid !== 1'b1 || m_axis_data.tdata !== 16'h8000) begin
      n_fail++;
      $display("FAIL ext_min: tvalid=%0b tdata=%0d, expected 1/-32768",
               m_axis_data.tvalid, $signed(m_axis_data.tdata));
    end
    step();
    drive(16'h7FFF); drive(16'h8000); drive(16'h7FFF); drive(16'h8000);
    n_checks++;
    if (m_axis_data.tvalid !== 1'b1 || m_axis_data.tdata !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL ext_mixed: tvalid=%0b tdata=%0d, expected 1/-1",
               m_axis_data.tvalid, $signed(m_axis_data.tdata));
    end
    step();
    n_checks++;
    if (fifo_level !== 4'd0) begin
      n_fail++;
      $display("FAIL ext_empty: level=%0d expected 0", fifo_level);
    end
  endtask

  // Output stalled. Values 0..39 are offered contiguously, and each value is
  // held until it is accepted.
  task automatic test_backpressure();
    int idx;
    idx                = 0;
    m_axis_data.tready = 1'b0;
    s_axis_data.tvalid = 1'b1;
    for (int cyc = 0; cyc < 48 && idx < 40; cyc++) begin
      s_axis_data.tdata = 16'(idx);
      if (s_axis_data.tready === 1'b1) begin
        step();
        idx++;
        if (idx == 32) begin
          n_checks++;
          if (fifo_level !== 4'd8 || s_axis_data.tready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full_at_32: level=%0d s_tready=%0b, expected 8/1",
                     fifo_level, s_axis_data.tready);
          end
        end
      end else begin
        step();
      end
    end
    n_checks++;
    if (idx !== 35) begin
      n_fail++;
      $display("FAIL bp_accepted: got %0d samples, expected 35", idx);
    end
    n_checks++;
    if (s_axis_data.tready !== 1'b0 || fifo_level !== 4'd8 || m_axis_data.tdata !== 16'd1) begin
      n_fail++;
      $display("FAIL bp_stalled: s_tready=%0b level=%0d head=%0d, expected 0/8/1",
               s_axis_data.tready, fifo_level, $signed(m_axis_data.tdata));
    end
  endtask

  // Entered with level 8, phase 3 and the closing sample (35) still offered.
  task automatic test_full_simultaneous();
    m_axis_data.tready = 1'b1;
    step();
    n_checks++;
    if (fifo_level !== 4'd7 || s_axis_data.tready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop_only: level=%0d s_tready=%0b, expected 7/1",
               fifo_level, s_axis_data.tready);
    end
    m_axis_data.tready = 1'b0;
    step();
    s_axis_data.tvalid = 1'b0;
    s_axis_data.tdata  = '0;
    n_checks++;
    if (fifo_level !== 4'd8) begin
      n_fail++;
      $display("FAIL full_late_push: level=%0d expected 8", fifo_level);
    end
  endtask

  // Drains 5, 9, ..., 29 and then 33 from the completed ninth group, one word
  // per cycle. Word 1 was popped in the previous task.
  task automatic test_drain();
    logic [15:0] exp_word;
    m_axis_data.tready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      exp_word = 16'(4 * i + 1);
      n_checks++;
      if (m_axis_data.tvalid !== 1'b1 || m_axis_data.tdata !== exp_word) begin
        n_fail++;
        $display("FAIL drain_word%0d: tvalid=%0b tdata=%0d, expected 1/%0d",
                 i, m_axis_data.tvalid, $signed(m_axis_data.tdata), exp_word);
      end
      step();
    end
    n_checks++;
    if (m_axis_data.tvalid !== 1'b0 || fifo_level !== 4'd0 || m_axis_data.tdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL drain_empty: tvalid=%0b level=%0d tdata=%0d, expected 0/0/0",
               m_axis_data.tvalid, fifo_level, m_axis_data.tdata);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_average();
    test_rounding();
    test_extremes();
    test_backpressure();
    test_full_simultaneous();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
